// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle direction encoding and screen geometry defaults
// used by the paddle controller, renderer and collision logic.
package pong_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam int POS_MIN  = 10;
  localparam int POS_MAX  = 370;
  localparam int PADDLE_H = 80;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every 2^DIV_W clocks, first tick
// 2^DIV_W cycles after reset release. Also used by the ball mover.
module tick_gen #(
  parameter int DIV_W = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign tick = &cnt;

endmodule

// File: rtl/paddle_ctrl.sv
// Vertical paddle controller: buttons or ball tracking drive a saturating
// paddle Y, updated on each divider tick with hold-to-accelerate ramping.
//   last_dir | meaning
//   NONE     | idle, auto mode, or both buttons held
//   UP/DOWN  | direction moved on the previous tick (ramp continues)
module paddle_ctrl #(
  parameter int POS_W       = 10,
  parameter int POS_MIN     = pong_pkg::POS_MIN,
  parameter int POS_MAX     = pong_pkg::POS_MAX,
  parameter int POS_INIT    = 220,
  parameter int TICK_DIV_W  = 17,
  parameter int SPEED_MAX   = 4,
  parameter int ACCEL_TICKS = 16,
  parameter int PADDLE_H    = pong_pkg::PADDLE_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up_n,
  input  logic             btn_dn_n,
  input  logic             auto_en,
  input  logic [POS_W-1:0] ball_y,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       speed,
  output logic             tick
);
  import pong_pkg::*;

  localparam int SW     = POS_W + 1;
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic signed [SW-1:0] MIN_S  = SW'(POS_MIN);
  localparam logic signed [SW-1:0] MAX_S  = SW'(POS_MAX);
  localparam logic signed [SW-1:0] HALF_H = SW'(PADDLE_H / 2);
  localparam logic signed [SW-1:0] SMAX_S = SW'(SPEED_MAX);
  localparam logic [2:0]           SPD_MAX  = 3'(SPEED_MAX);
  localparam logic [HOLD_W-1:0]    ACCEL_M1 = HOLD_W'(ACCEL_TICKS - 1);
  localparam logic [POS_W-1:0]     INIT_V   = POS_W'(POS_INIT);

  logic up_s1, up_s2, dn_s1, dn_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_s1 <= 1'b1;
      up_s2 <= 1'b1;
      dn_s1 <= 1'b1;
      dn_s2 <= 1'b1;
    end else begin
      up_s1 <= btn_up_n;
      up_s2 <= up_s1;
      dn_s1 <= btn_dn_n;
      dn_s2 <= dn_s1;
    end
  end

  tick_gen #(.DIV_W(TICK_DIV_W)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  dir_t                 last_dir, last_dir_nxt, dir_btn, mv_dir;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [2:0]           speed_nxt;
  logic signed [SW-1:0] pos_s, target, diff, adiff, step_s, cand;

  always_comb begin
    dir_btn = DIR_NONE;
    if (!up_s2 && dn_s2)      dir_btn = DIR_UP;
    else if (up_s2 && !dn_s2) dir_btn = DIR_DOWN;
  end

  always_comb begin
    pos_s  = signed'({1'b0, pos_y});
    target = signed'({1'b0, ball_y}) - HALF_H;
    if (target < MIN_S)      target = MIN_S;
    else if (target > MAX_S) target = MAX_S;
    diff  = target - pos_s;
    adiff = diff[SW-1] ? -diff : diff;

    mv_dir       = DIR_NONE;
    speed_nxt    = 3'd0;
    hold_nxt     = '0;
    last_dir_nxt = DIR_NONE;

    if (auto_en) begin
      if (diff != '0) begin
        mv_dir    = diff[SW-1] ? DIR_UP : DIR_DOWN;
        speed_nxt = (adiff > SMAX_S) ? SPD_MAX : adiff[2:0];
      end
    end else if (dir_btn != DIR_NONE) begin
      mv_dir       = dir_btn;
      last_dir_nxt = dir_btn;
      if (dir_btn != last_dir) begin
        speed_nxt = 3'd1;
      end else if (hold_cnt == ACCEL_M1) begin
        speed_nxt = (speed < SPD_MAX) ? speed + 3'd1 : SPD_MAX;
      end else begin
        hold_nxt  = hold_cnt + 1'b1;
        speed_nxt = speed;
      end
    end

    // Step applied in signed width so the limit compare cannot wrap.
    step_s = signed'({{(SW-3){1'b0}}, speed_nxt});
    cand   = pos_s;
    if (mv_dir == DIR_UP) begin
      cand = pos_s - step_s;
      if (cand < MIN_S) cand = MIN_S;
    end else if (mv_dir == DIR_DOWN) begin
      cand = pos_s + step_s;
      if (cand > MAX_S) cand = MAX_S;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_y    <= INIT_V;
      speed    <= 3'd0;
      hold_cnt <= '0;
      last_dir <= DIR_NONE;
    end else if (tick) begin
      pos_y    <= cand[POS_W-1:0];
      speed    <= speed_nxt;
      hold_cnt <= hold_nxt;
      last_dir <= last_dir_nxt;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with a fast divider (tick every 8 clk), SPEED_MAX=4, ACCEL_TICKS=2.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_n, btn_dn_n, auto_en;
  logic [9:0] ball_y;
  logic [9:0] pos_y;
  logic [2:0] speed;
  logic       tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       up_n;
    logic       dn_n;
    logic       auto;
    logic [9:0] ball;
    int         exp_pos;
    int         exp_spd;
  } vec_t;

  typedef struct {
    int pos;
    int spd;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  paddle_ctrl #(
    .POS_W(10), .POS_MIN(10), .POS_MAX(370), .POS_INIT(220),
    .TICK_DIV_W(3), .SPEED_MAX(4), .ACCEL_TICKS(2), .PADDLE_H(80)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .auto_en  (auto_en),
    .ball_y   (ball_y),
    .pos_y    (pos_y),
    .speed    (speed),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic u, input logic d, input logic a,
                              input int by, input int p, input int s);
    vec_t v;
    v.up_n = u; v.dn_n = d; v.auto = a; v.ball = 10'(by);
    v.exp_pos = p; v.exp_spd = s;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, " pos_y"}, int'(pos_y), e.pos);
    chk({tag, " speed"}, int'(speed), e.spd);
    chk({tag, " tick_low"}, int'(tick), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit   ok;
    exp_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    btn_up_n = v.up_n;
    btn_dn_n = v.dn_n;
    auto_en  = v.auto;
    ball_y   = v.ball;
    e.pos = v.exp_pos; e.spd = v.exp_spd;
    exp_q.push_back(e);
    wait_tick(ok);
    if (!ok) begin
      chk({tag, " tick_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      @(posedge clk); #1;
      pop_check(tag);
    end
  endtask

  task automatic first_tick_latency(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
    // Tick is visible during the 8th cycle after release; the update lands on its closing edge.
    chk(name, n, 7);
  endtask

  initial begin
    int   tcount;
    bit   prev_t, dbl;
    exp_t e;

    rst = 1'b1; btn_up_n = 1'b1; btn_dn_n = 1'b1; auto_en = 1'b0; ball_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pos_y", int'(pos_y), 220);
    chk("reset speed", int'(speed), 0);
    chk("reset tick", int'(tick), 0);

    @(negedge clk) rst = 1'b0;
    first_tick_latency("first_tick_cycle");
    @(posedge clk); #1;
    chk("idle pos_y after first tick", int'(pos_y), 220);

    tcount = 0; prev_t = 1'b0; dbl = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tick) tcount++;
      if (tick && prev_t) dbl = 1'b1;
      prev_t = tick;
    end
    chk("ticks in 80 clk", tcount, 10);
    chk("tick single cycle", int'(dbl), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 220, 0);
    add(0, 1, 0, 0, 219, 1); add(0, 1, 0, 0, 218, 1);
    add(0, 1, 0, 0, 216, 2); add(0, 1, 0, 0, 214, 2);
    add(0, 1, 0, 0, 211, 3); add(0, 1, 0, 0, 208, 3);
    add(0, 1, 0, 0, 204, 4); add(0, 1, 0, 0, 200, 4);
    add(0, 1, 0, 0, 196, 4); add(0, 1, 0, 0, 192, 4);
    add(0, 0, 0, 0, 192, 0);
    add(0, 1, 0, 0, 191, 1);
    for (int k = 1; k <= 17; k++) add(1, 1, 1, 300, 191 + 4 * k, 4);
    add(1, 1, 1, 300, 260, 1);
    add(1, 1, 1, 300, 260, 0);
    for (int k = 1; k <= 27; k++) add(0, 0, 1, 408, 260 + 4 * k, 4);
    add(0, 0, 1, 408, 368, 0);
    add(1, 0, 0, 0, 369, 1); add(1, 0, 0, 0, 370, 1);
    add(1, 0, 0, 0, 370, 2); add(1, 0, 0, 0, 370, 2);
    add(1, 0, 0, 0, 370, 3); add(1, 0, 0, 0, 370, 3);
    add(1, 0, 0, 0, 370, 4); add(1, 0, 0, 0, 370, 4);
    add(1, 1, 0, 0, 370, 0);
    for (int k = 1; k <= 90; k++) add(1, 1, 1, 5, 370 - 4 * k, 4);
    add(1, 1, 1, 5, 10, 0);
    for (int k = 1; k <= 37; k++) add(1, 1, 1, 200, 10 + 4 * k, 4);
    add(1, 1, 1, 200, 160, 2);
    add(1, 1, 1, 200, 160, 0);
    for (int k = 1; k <= 52; k++) add(1, 1, 1, 1023, 160 + 4 * k, 4);
    add(1, 1, 1, 1023, 370, 2);
    add(1, 1, 1, 1023, 370, 0);
    add(1, 0, 0, 0, 370, 1);
    add(0, 1, 0, 0, 369, 1); add(0, 1, 0, 0, 368, 1);
    add(0, 1, 0, 0, 366, 2); add(0, 1, 0, 0, 364, 2);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset in the middle of a ramp, between ticks, with the button still held.
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset pos_y", int'(pos_y), 220);
    chk("midreset speed", int'(speed), 0);
    chk("midreset tick", int'(tick), 0);
    repeat (2) @(posedge clk);
    e.pos = 219; e.spd = 1;
    exp_q.push_back(e);
    @(negedge clk) rst = 1'b0;
    first_tick_latency("post_reset_first_tick_cycle");
    @(posedge clk); #1;
    pop_check("post_reset ramp restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
